// File: rtl/mat_dsp_tree_acc.sv
// Multi-column dual-mode multiply slice: per-lane products, registered adder tree,
// and a saturating accumulator over ci tiles with first/last framing.
module mat_dsp_tree_acc #(
    parameter int MAT_WIDTH = 4,
    parameter int MULT_LAT  = 2,
    parameter int ACC_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic                     acc_first,
    input  logic                     acc_last,
    input  logic                     mode,
    input  logic [16*MAT_WIDTH-1:0]  I_A,
    input  logic [16*MAT_WIDTH-1:0]  I_W,
    output logic [2*ACC_WIDTH-1:0]   O,
    output logic                     out_valid,
    output logic                     ovf
);

    localparam int LOG2W = $clog2(MAT_WIDTH);
    localparam int LAT   = MULT_LAT + LOG2W + 1;
    localparam int PIPE  = LAT - 1;
    localparam int TW    = 17 + LOG2W;
    localparam int SW    = ((ACC_WIDTH > TW) ? ACC_WIDTH : TW) + 1;
    localparam int NODES = MAT_WIDTH - 1;

    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    logic open_acc;
    logic mode_hold;
    logic eff_first;
    logic eff_mode;

    // A non-first beat with nothing open starts a fresh accumulation.
    assign eff_first = acc_first | ~open_acc;
    assign eff_mode  = eff_first ? mode : mode_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            open_acc  <= 1'b0;
            mode_hold <= 1'b0;
        end else if (en && in_valid) begin
            open_acc <= ~acc_last;
            if (eff_first)
                mode_hold <= mode;
        end
    end

    logic signed [TW-1:0] col0 [MAT_WIDTH];
    logic signed [TW-1:0] col1 [MAT_WIDTH];

    // Each column sums its two lanes, as the DSP slice would internally.
    always_comb begin : lane_products
        logic signed [15:0] a16;
        logic signed [15:0] w_a;
        logic signed [15:0] w_b;
        logic signed [15:0] prod0;
        logic signed [15:0] prod1;
        logic signed [TW-1:0] ext0;
        logic signed [TW-1:0] ext1;
        a16 = '0; w_a = '0; w_b = '0; prod0 = '0; prod1 = '0; ext0 = '0; ext1 = '0;
        for (int j = 0; j < MAT_WIDTH; j++) begin
            col0[j] = '0;
            col1[j] = '0;
            for (int p = 0; p < 2; p++) begin
                a16 = signed'(I_A[8*(2*j+p) +: 8]);
                if (eff_mode) begin
                    w_a = signed'(I_W[8*(2*j+p) +: 4]);
                    w_b = signed'(I_W[8*(2*j+p)+4 +: 4]);
                end else begin
                    w_a = signed'(I_W[8*(2*j+p) +: 8]);
                    w_b = '0;
                end
                prod0 = a16 * w_a;
                prod1 = a16 * w_b;
                ext0 = prod0;
                ext1 = prod1;
                col0[j] = col0[j] + ext0;
                col1[j] = col1[j] + ext1;
            end
        end
    end

    logic signed [TW-1:0] m0 [MULT_LAT][MAT_WIDTH];
    logic signed [TW-1:0] m1 [MULT_LAT][MAT_WIDTH];
    logic [PIPE-1:0]      v_pipe;
    logic [PIPE-1:0]      f_pipe;
    logic [PIPE-1:0]      l_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MULT_LAT; s++)
                for (int j = 0; j < MAT_WIDTH; j++) begin
                    m0[s][j] <= '0;
                    m1[s][j] <= '0;
                end
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
        end else if (en) begin
            for (int j = 0; j < MAT_WIDTH; j++) begin
                m0[0][j] <= col0[j];
                m1[0][j] <= col1[j];
            end
            for (int s = 1; s < MULT_LAT; s++)
                for (int j = 0; j < MAT_WIDTH; j++) begin
                    m0[s][j] <= m0[s-1][j];
                    m1[s][j] <= m1[s-1][j];
                end
            v_pipe <= {v_pipe[PIPE-2:0], in_valid};
            f_pipe <= {f_pipe[PIPE-2:0], eff_first};
            l_pipe <= {l_pipe[PIPE-2:0], acc_last};
        end
    end

    // Heap-ordered tree: node i adds children 2i+1 and 2i+2; leaves follow the nodes.
    logic signed [TW-1:0] node0 [NODES];
    logic signed [TW-1:0] node1 [NODES];
    logic signed [TW-1:0] full0 [2*MAT_WIDTH-1];
    logic signed [TW-1:0] full1 [2*MAT_WIDTH-1];

    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            full0[i] = node0[i];
            full1[i] = node1[i];
        end
        for (int j = 0; j < MAT_WIDTH; j++) begin
            full0[NODES+j] = m0[MULT_LAT-1][j];
            full1[NODES+j] = m1[MULT_LAT-1][j];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NODES; i++) begin
                node0[i] <= '0;
                node1[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < NODES; i++) begin
                node0[i] <= full0[2*i+1] + full0[2*i+2];
                node1[i] <= full1[2*i+1] + full1[2*i+2];
            end
        end
    end

    function automatic logic [ACC_WIDTH:0] saturate(input logic signed [SW-1:0] s);
        if (s > ACC_MAX)
            return {1'b1, ACC_MAX[ACC_WIDTH-1:0]};
        else if (s < ACC_MIN)
            return {1'b1, ACC_MIN[ACC_WIDTH-1:0]};
        return {1'b0, s[ACC_WIDTH-1:0]};
    endfunction

    logic signed [ACC_WIDTH-1:0] acc0;
    logic signed [ACC_WIDTH-1:0] acc1;
    logic                        sticky;
    logic signed [SW-1:0]        base0, base1, root0, root1;
    logic [ACC_WIDTH:0]          res0, res1;
    logic                        new_flag;

    always_comb begin
        base0 = '0;
        base1 = '0;
        if (!f_pipe[PIPE-1]) begin
            base0 = acc0;
            base1 = acc1;
        end
        root0 = node0[0];
        root1 = node1[0];
        res0 = saturate(base0 + root0);
        res1 = saturate(base1 + root1);
        new_flag = res0[ACC_WIDTH] | res1[ACC_WIDTH] | (sticky & ~f_pipe[PIPE-1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc0      <= '0;
            acc1      <= '0;
            sticky    <= 1'b0;
            O         <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= v_pipe[PIPE-1] & l_pipe[PIPE-1];
            if (v_pipe[PIPE-1]) begin
                acc0   <= res0[ACC_WIDTH-1:0];
                acc1   <= res1[ACC_WIDTH-1:0];
                sticky <= new_flag;
                if (l_pipe[PIPE-1]) begin
                    O   <= {res1[ACC_WIDTH-1:0], res0[ACC_WIDTH-1:0]};
                    ovf <= new_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_dsp_tree_acc.sv
// Directed bench for mat_dsp_tree_acc: vector table of uniform-lane accumulations
// plus hand sequences for stalls, back-to-back framing, discard and reset.
module tb_mat_dsp_tree_acc;

    localparam int MAT_WIDTH = 4;
    localparam int ACC_WIDTH = 24;
    localparam int LAT       = 5;

    typedef struct {
        logic       mode;
        logic [7:0] a;
        logic [7:0] w;
        int         beats;
        int         co0;
        int         co1;
        logic       ovf;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    en;
    logic                    in_valid;
    logic                    acc_first;
    logic                    acc_last;
    logic                    mode;
    logic [16*MAT_WIDTH-1:0] I_A;
    logic [16*MAT_WIDTH-1:0] I_W;
    logic [2*ACC_WIDTH-1:0]  O;
    logic                    out_valid;
    logic                    ovf;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    vec_t vecs [9];

    mat_dsp_tree_acc #(.MAT_WIDTH(MAT_WIDTH), .MULT_LAT(2), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .mode(mode),
        .I_A(I_A), .I_W(I_W), .O(O), .out_valid(out_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Each enabled edge that sees out_valid high consumes exactly one result pulse.
    always @(posedge clk) if (en && out_valid) pulses++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic f, input logic l, input logic m,
                                  input logic [7:0] a, input logic [7:0] w);
        in_valid  = v;
        acc_first = f;
        acc_last  = l;
        mode      = m;
        I_A       = {(2*MAT_WIDTH){a}};
        I_W       = {(2*MAT_WIDTH){w}};
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        acc_first = 1'b0;
        acc_last  = 1'b0;
    endtask

    task automatic wait_out(input string name, output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_output({name, " out_valid_seen"}, 48'(out_valid), 48'd1);
    endtask

    task automatic check_result(input string name, input int e0, input int e1, input logic eovf);
        logic [23:0] x0;
        logic [23:0] x1;
        x0 = e0[23:0];
        x1 = e1[23:0];
        check_output({name, " co0"}, 48'(O[23:0]), 48'(x0));
        check_output({name, " co1"}, 48'(O[47:24]), 48'(x1));
        check_output({name, " ovf"}, 48'(ovf), 48'(eovf));
    endtask

    task automatic check_drop(input string name, input int p0, input int n);
        @(posedge clk);
        #1;
        check_output({name, " pulse_drop"}, 48'(out_valid), 48'd0);
        check_output({name, " pulse_count"}, 48'(pulses - p0), 48'(n));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int    cnt;
        int    p0;
        string nm;
        nm = $sformatf("vec%0d", idx);
        p0 = pulses;
        for (int b = 0; b < v.beats; b++)
            apply_stimulus(1'b1, b == 0, b == v.beats - 1, v.mode, v.a, v.w);
        idle();
        wait_out(nm, cnt);
        check_output({nm, " latency"}, 48'(cnt), 48'(LAT - 1));
        check_result(nm, v.co0, v.co1, v.ovf);
        check_drop(nm, p0, 1);
    endtask

    initial begin
        int cnt;
        int p0;

        vecs[0] = '{1'b0, 8'h01, 8'h01, 1,  8,        0,     1'b0};
        vecs[1] = '{1'b0, 8'h80, 8'h80, 3,  393216,   0,     1'b0};
        vecs[2] = '{1'b1, 8'h03, 8'hF2, 1,  48,       -24,   1'b0};
        vecs[3] = '{1'b0, 8'h80, 8'h80, 70, 8388607,  0,     1'b1};
        vecs[4] = '{1'b0, 8'h01, 8'h01, 1,  8,        0,     1'b0};
        vecs[5] = '{1'b1, 8'hFB, 8'h7F, 1,  40,       -280,  1'b0};
        vecs[6] = '{1'b0, 8'h7F, 8'h80, 2,  -260096,  0,     1'b0};
        vecs[7] = '{1'b1, 8'h80, 8'h88, 4,  32768,    32768, 1'b0};
        vecs[8] = '{1'b0, 8'h7F, 8'h80, 70, -8388608, 0,     1'b1};

        reset = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        I_A   = '0;
        I_W   = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_output("reset O", 48'(O), 48'd0);
        check_output("reset out_valid", 48'(out_valid), 48'd0);
        check_output("reset ovf", 48'(ovf), 48'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            run_vec(i, vecs[i]);

        // Reset while an accumulation is open and beats are in flight.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);
        idle();
        reset = 1'b0;
        #1;
        check_output("midreset O", 48'(O), 48'd0);
        check_output("midreset out_valid", 48'(out_valid), 48'd0);
        check_output("midreset ovf", 48'(ovf), 48'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        p0 = pulses;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h01);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 8'h01);
        idle();
        wait_out("postreset", cnt);
        check_result("postreset", 32, 0, 1'b0);
        check_drop("postreset", p0, 1);

        // Stall mid-stream with junk on the inputs and a mode flip on later beats.
        p0 = pulses;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'hF2);
        en = 1'b0;
        repeat (3) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'h11);
        en = 1'b1;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'hF2);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'hF2);
        idle();
        wait_out("stall", cnt);
        check_result("stall", 144, -72, 1'b0);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("stall pulse_hold", 48'(out_valid), 48'd1);
        en = 1'b1;
        check_drop("stall", p0, 1);

        // Back-to-back single-beat accumulations.
        p0 = pulses;
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h01);
        idle();
        wait_out("b2b", cnt);
        check_output("b2b latency", 48'(cnt), 48'(LAT - 2));
        check_result("b2b first", 8, 0, 1'b0);
        @(posedge clk);
        #1;
        check_output("b2b second out_valid", 48'(out_valid), 48'd1);
        check_result("b2b second", 16, 0, 1'b0);
        check_drop("b2b", p0, 2);

        // Non-first beat with nothing open starts a new sum.
        p0 = pulses;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
        idle();
        wait_out("implicit_first", cnt);
        check_result("implicit_first", 16, 0, 1'b0);
        check_drop("implicit_first", p0, 1);

        // A new first beat discards the open sum without producing output.
        p0 = pulses;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
        idle();
        wait_out("discard", cnt);
        check_result("discard", 8, 0, 1'b0);
        check_drop("discard", p0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
